// File: rtl/lamp_conflict_monitor_pkg.sv
// Shared lamp bit positions, fault codes and monitor state encodings for the
// lamp-side conflict monitor.
package lamp_conflict_monitor_pkg;

  localparam int LAMP_R  = 4;
  localparam int LAMP_Y  = 3;
  localparam int LAMP_G  = 2;
  localparam int LAMP_DW = 1;
  localparam int LAMP_W  = 0;

  typedef enum logic [2:0] {
    FLT_NONE         = 3'd0,
    FLT_VEH_CONFLICT = 3'd1,
    FLT_PED_CONFLICT = 3'd2,
    FLT_MULTI_ASPECT = 3'd3,
    FLT_DARK         = 3'd4,
    FLT_SHORT_YEL    = 3'd5
  } fault_code_e;

  typedef enum logic [1:0] {
    ST_HOLDOFF = 2'd0,
    ST_ARMED   = 2'd1,
    ST_TRIPPED = 2'd2
  } mon_state_e;

  // Vehicle movement permitted on this approach (yellow or green lit).
  function automatic logic veh_moving(input logic [4:0] v);
    return v[LAMP_Y] | v[LAMP_G];
  endfunction

  function automatic logic multi_aspect(input logic [4:0] v);
    return (v[LAMP_R] & v[LAMP_Y]) | (v[LAMP_R] & v[LAMP_G]) |
           (v[LAMP_Y] & v[LAMP_G]) | (v[LAMP_DW] & v[LAMP_W]);
  endfunction

endpackage

// File: rtl/lamp_conflict_monitor_persist_filter.sv
// Persistence filter: hit is high once cond has been true for N consecutive
// cycles, and stays high while cond remains true.
module lamp_conflict_monitor_persist_filter #(
  parameter int N = 4
) (
  input  logic clock,
  input  logic resetn,
  input  logic hold_clr,
  input  logic cond,
  output logic hit
);

  localparam int            CW    = $clog2(N + 1);
  localparam logic [CW-1:0] N_CNT = CW'(N);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (hold_clr || !cond) begin
      cnt_d = '0;
    end else if (cnt_q != N_CNT) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign hit = (cnt_q == N_CNT);

endmodule

// File: rtl/lamp_conflict_monitor.sv
// Independent lamp-drive conflict monitor: validates the two read-back lamp
// vectors, latches the first fault and forces flashing-red while tripped.
module lamp_conflict_monitor
  import lamp_conflict_monitor_pkg::*;
#(
  parameter int PERSIST_CYC = 2_500_000,
  parameter int DARK_CYC    = 30_000_000,
  parameter int MIN_YEL_CYC = 150_000_000,
  parameter int HOLDOFF_CYC = 100_000_000
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [4:0] set1,
  input  logic [4:0] set2,
  input  logic       mode_flash,
  input  logic       clear_fault,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic [7:0] fault_count,
  output logic       force_flash
);

  localparam int            YW        = $clog2(MIN_YEL_CYC + 1);
  localparam logic [YW-1:0] YEL_MIN   = YW'(MIN_YEL_CYC);
  localparam int            HW        = $clog2(HOLDOFF_CYC + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLDOFF_CYC - 1);

  logic [4:0]  set_q [2];
  logic        mode_flash_q;
  logic [3:0]  raw_cond;
  logic [3:0]  hit;
  logic [1:0]  short_yel;
  fault_code_e trip_code;

  mon_state_e  state_q;
  logic [HW-1:0] hold_tmr_q;
  logic        fault_q;
  logic        force_flash_q;
  logic [2:0]  fault_code_q;
  logic [7:0]  fault_count_q;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      set_q[0]     <= '0;
      set_q[1]     <= '0;
      mode_flash_q <= 1'b0;
    end else begin
      set_q[0]     <= set1;
      set_q[1]     <= set2;
      mode_flash_q <= mode_flash;
    end
  end

  always_comb begin
    raw_cond[0] = veh_moving(set_q[0]) & veh_moving(set_q[1]);
    raw_cond[1] = (set_q[0][LAMP_W] & veh_moving(set_q[1])) |
                  (set_q[1][LAMP_W] & veh_moving(set_q[0]));
    raw_cond[2] = multi_aspect(set_q[0]) | multi_aspect(set_q[1]);
    raw_cond[3] = ~mode_flash_q &
                  ((set_q[0][LAMP_R:LAMP_G] == 3'b000) | (set_q[1][LAMP_R:LAMP_G] == 3'b000));
  end

  // Filters restart from zero on every HOLDOFF cycle so a fresh arming never
  // inherits history.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_filt
      lamp_conflict_monitor_persist_filter #(
        .N((gi == 3) ? DARK_CYC : PERSIST_CYC)
      ) u_filt (
        .clock   (clock),
        .resetn  (resetn),
        .hold_clr(state_q == ST_HOLDOFF),
        .cond    (raw_cond[gi]),
        .hit     (hit[gi])
      );
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_yel
      logic [YW-1:0] yel_tmr_q;
      logic          y_prev_q;

      always_ff @(posedge clock) begin
        if (!resetn) begin
          yel_tmr_q <= '0;
          y_prev_q  <= 1'b0;
        end else begin
          y_prev_q <= set_q[gi][LAMP_Y];
          if (state_q == ST_HOLDOFF || !set_q[gi][LAMP_Y]) begin
            yel_tmr_q <= '0;
          end else if (yel_tmr_q != YEL_MIN) begin
            yel_tmr_q <= yel_tmr_q + YW'(1);
          end
        end
      end

      // Timer still holds the full yellow length in the cycle the fall is seen.
      assign short_yel[gi] = y_prev_q & ~set_q[gi][LAMP_Y] & (yel_tmr_q < YEL_MIN) & ~mode_flash_q;
    end
  endgenerate

  always_comb begin
    trip_code = FLT_NONE;
    if (hit[0]) begin
      trip_code = FLT_VEH_CONFLICT;
    end else if (hit[1]) begin
      trip_code = FLT_PED_CONFLICT;
    end else if (hit[2]) begin
      trip_code = FLT_MULTI_ASPECT;
    end else if (hit[3]) begin
      trip_code = FLT_DARK;
    end else if (|short_yel) begin
      trip_code = FLT_SHORT_YEL;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q       <= ST_HOLDOFF;
      hold_tmr_q    <= '0;
      fault_q       <= 1'b0;
      force_flash_q <= 1'b1;
      fault_code_q  <= FLT_NONE;
      fault_count_q <= '0;
    end else begin
      case (state_q)
        ST_HOLDOFF: begin
          if (hold_tmr_q == HOLD_LAST) begin
            state_q       <= ST_ARMED;
            force_flash_q <= 1'b0;
          end else begin
            hold_tmr_q <= hold_tmr_q + HW'(1);
          end
        end
        ST_ARMED: begin
          if (trip_code != FLT_NONE) begin
            state_q       <= ST_TRIPPED;
            fault_q       <= 1'b1;
            force_flash_q <= 1'b1;
            fault_code_q  <= trip_code;
            if (fault_count_q != 8'hFF) begin
              fault_count_q <= fault_count_q + 8'd1;
            end
          end
        end
        ST_TRIPPED: begin
          // Clear only counts once the lamps are actually clean again.
          if (clear_fault && raw_cond == 4'b0000) begin
            state_q    <= ST_HOLDOFF;
            hold_tmr_q <= '0;
            fault_q    <= 1'b0;
          end
        end
        default: begin
          state_q       <= ST_HOLDOFF;
          hold_tmr_q    <= '0;
          fault_q       <= 1'b0;
          force_flash_q <= 1'b1;
        end
      endcase
    end
  end

  assign fault       = fault_q;
  assign force_flash = force_flash_q;
  assign fault_code  = fault_code_q;
  assign fault_count = fault_count_q;

endmodule
